// File: rtl/aes_inv_key_schedule.sv
// Reverse-order AES-128 round-key generator: forward-expands a loaded key to round 10,
// then streams keys 10..0 by inverting one expansion step per handshake.
// Optional round-10 key cache: define AES_INV_KS_CACHE_EN.

module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  assign y = SBOX[a];
endmodule

module aes_inv_key_schedule (
  input  logic         clk,
  input  logic         g_rst_n,
  input  logic         key_load,
  input  logic [127:0] key_in,
  input  logic         start,
  output logic         busy,
  output logic         key_ready,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_round,
  output logic         rk_last
);
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {IDLE, EXPAND, READY, STREAM} state_t;

  state_t       state;
  logic [127:0] work;
  logic [3:0]   round;
  logic         top;
`ifdef AES_INV_KS_CACHE_EN
  logic [127:0] cache;
`else
  logic         auto_stream;
`endif

  logic [31:0] w0, w1, w2, w3, inv_w3, sb_in, rot, sub, rcon_w;
  logic [31:0] f0, f1, f2, f3, i0, i1, i2;

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  assign {w0, w1, w2, w3} = work;
  assign inv_w3 = w3 ^ w2;

  // One shared S-box word: forward step substitutes W3, inverse step the new W3'.
  assign sb_in = (state == STREAM) ? inv_w3 : w3;
  assign rot   = {sb_in[23:0], sb_in[31:24]};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_sbox
    aes_sbox u_sbox (.a(rot[8*i +: 8]), .y(sub[8*i +: 8]));
  end

  assign rcon_w = {rcon(round), 24'h0};

  assign f0 = w0 ^ sub ^ rcon_w;
  assign f1 = w1 ^ f0;
  assign f2 = w2 ^ f1;
  assign f3 = w3 ^ f2;

  assign i0 = w0 ^ sub ^ rcon_w;
  assign i1 = w1 ^ w0;
  assign i2 = w2 ^ w1;

  always_ff @(posedge clk or negedge g_rst_n) begin
    if (!g_rst_n) begin
      state <= IDLE;
      work  <= '0;
      round <= '0;
      top   <= 1'b0;
`ifdef AES_INV_KS_CACHE_EN
      cache <= '0;
`else
      auto_stream <= 1'b0;
`endif
    end else if (key_load) begin
      work  <= key_in;
      round <= 4'd1;
      top   <= 1'b0;
      state <= EXPAND;
`ifndef AES_INV_KS_CACHE_EN
      auto_stream <= 1'b0;
`endif
    end else begin
      case (state)
        EXPAND: begin
          work <= {f0, f1, f2, f3};
          if (round == 4'd10) begin
            top <= 1'b1;
`ifdef AES_INV_KS_CACHE_EN
            cache <= {f0, f1, f2, f3};
            state <= READY;
`else
            // A re-expansion triggered by start continues straight into the stream.
            state       <= auto_stream ? STREAM : READY;
            auto_stream <= 1'b0;
`endif
          end else begin
            round <= round + 4'd1;
          end
        end
        READY: begin
          if (start) begin
`ifdef AES_INV_KS_CACHE_EN
            work  <= cache;
            round <= 4'd10;
            top   <= 1'b1;
            state <= STREAM;
`else
            if (top) begin
              state <= STREAM;
            end else begin
              round       <= 4'd1;
              auto_stream <= 1'b1;
              state       <= EXPAND;
            end
`endif
          end
        end
        STREAM: begin
          if (rk_ready) begin
            if (round != 4'd0) begin
              work  <= {i0, i1, i2, inv_w3};
              round <= round - 4'd1;
            end else begin
              top   <= 1'b0;
              state <= READY;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state == EXPAND) || (state == STREAM);
  assign key_ready = (state == READY);
  assign rk_valid  = (state == STREAM);
  assign rk_out    = work;
  assign rk_round  = round;
  assign rk_last   = rk_valid && (round == 4'd0);

endmodule

// File: doc/aes_inv_key_schedule.md
# aes_inv_key_schedule

Reverse-order AES-128 round-key generator for the decryption datapath. It loads a cipher key and runs a 10-cycle forward expansion to reach the round-10 key. On each start it streams round keys 10 down to 0 over a valid/ready handshake, deriving each one by inverting one key-expansion step. It feeds the inverse-cipher round engine, which consumes keys last-round-first.

## Interface
Parameters: none; the block is fixed to AES-128 (Nk=4, Nr=10).

Ports:
- clk  in  1  rising-edge clock
- g_rst_n  in  1  asynchronous active-low reset
- key_load  in  1  one-cycle pulse; capture key_in and start forward expansion
- key_in  in  128  cipher key, word W0 = [127:96]
- start  in  1  begin a reverse stream; honoured only in READY
- busy  out  1  high in EXPAND or STREAM
- key_ready  out  1  high in READY
- rk_valid  out  1  rk_out is valid
- rk_ready  in  1  consumer accepts rk_out
- rk_out  out  128  current round key
- rk_round  out  4  round index of rk_out, 10..0
- rk_last  out  1  equals rk_valid & (rk_round == 0)

## Operation
- State: 128-bit work register, 4-bit round counter, top flag (work holds the round-10 key).
- FSM states are IDLE, EXPAND, READY, STREAM.
- Forward step fwd(K,r):
  - W0' = W0 ^ SubWord(RotWord(W3)) ^ Rcon(r)
  - W1' = W1 ^ W0'
  - W2' = W2 ^ W1'
  - W3' = W3 ^ W2'
- Inverse step inv(K,r), producing key r-1 from key r:
  - W3' = W3 ^ W2
  - W2' = W2 ^ W1
  - W1' = W1 ^ W0
  - W0' = W0 ^ SubWord(RotWord(W3')) ^ Rcon(r)
- Rcon(r) sits in the MSB byte, r=1..10: 01,02,04,08,10,20,40,80,1b,36.
- One S-box word (4 S-boxes) is shared; its input is muxed by state.
- key_load in any state, including mid-EXPAND and mid-STREAM:
  - work <= key_in, round <= 1, top <= 0, state EXPAND.
  - An active stream is aborted; rk_valid falls on the next edge.
- EXPAND, each cycle:
  - work <= fwd(work, round), round <= round+1.
  - After the round-10 step: top <= 1, round <= 10, state READY.
- READY with start:
  - If top=1: state STREAM.
  - If top=0: re-enter EXPAND from the round-0 key in work, with round <= 1. This requires the work register to hold the round-0 key when top=0: IDLE cannot reach READY, and every completed or aborted-by-load stream leaves either the round-0 key or a fresh load in work. After that expansion the block proceeds directly to STREAM.
- STREAM: rk_out = work, rk_round = round, rk_valid = 1. On rk_valid & rk_ready:
  - round > 0: work <= inv(work, round), round <= round-1.
  - round = 0: top <= 0, state READY.
- With rk_ready low, rk_out and rk_round hold stable.
- start outside READY is ignored.
- key_load and start in the same cycle: key_load wins.

## Timing
- Reset values: all outputs 0, state IDLE, work 0, round 0, top 0.
- key_load sampled at edge N: key_ready rises after edge N+10, i.e. the 10 EXPAND cycles are N+1..N+10.
- start sampled in READY with top=1: rk_valid=1 and rk_round=10 after the next edge.
- start with top=0, without the cache: rk_valid rises after 10 EXPAND cycles plus 1 edge.
- With rk_ready held high: one key per cycle; 11 keys in 11 cycles; key_ready returns the cycle after the round-0 handshake.
- rk_out is registered; there is no combinational path from rk_ready to rk_out.

## Configuration
- AES_INV_KS_CACHE_EN is the compile-time switch for a round-10 key cache.
- Defined:
  - A 128-bit cache register captures the round-10 key at the end of EXPAND.
  - start in READY always loads work <= cache and round <= 10 and enters STREAM, so first rk_valid follows 1 edge after start.
  - key_load overwrites the cache on its next EXPAND completion.
  - Reset clears the cache.
- Undefined: no cache; start with top=0 re-runs EXPAND as described in Operation.

## Test plan
- Reset and FIPS-197 load:
  - Assert g_rst_n low: all outputs 0.
  - key_load with key_in=2b7e151628aed2a6abf7158809cf4f3c -> key_ready after 10 cycles.
  - start -> rk_round=10, rk_out=d014f9a8c9ee2589e13f0cc8b6630ca6.
- Full stream with rk_ready=1:
  - rk_round 9 -> ac7766f319fadc2128d12941575c006e.
  - rk_round 1 -> a0fafe1788542cb123a339392a6c7605.
  - rk_round 0 -> 2b7e1516... with rk_last=1.
  - Then key_ready=1, busy=0.
- Backpressure:
  - Hold rk_ready=0 for 5 cycles at rk_round=7 -> rk_out/rk_round stable.
  - Release -> round 6 key next cycle.
- Second start without the cache -> 11-cycle latency, identical key sequence. With AES_INV_KS_CACHE_EN -> 1-cycle latency.
- Abort: key_load of a new key at rk_round=4 -> rk_valid low next edge, fresh EXPAND, new key's round-10 key streamed after start.
- Collisions: start and key_load in the same cycle in READY -> EXPAND taken. Async reset mid-EXPAND -> immediate zero outputs, IDLE.
